ram_b_mem: RTL and testbench

- Byte-addressable data memory for the memory functional unit of the Tomasulo core.
- Supports RISC-V byte, halfword and word accesses, selected by a 3-bit funct3-style size code.
- Loads are read combinationally with sign or zero extension; stores are written synchronously with byte-lane enables.
- The FU presents a registered address, expects load data to be valid before the next clock edge, and drives the write enable one cycle after it captures the store.

---
 rtl/ram_b_pkg.sv | 12 +
 rtl/ram_b_load_align.sv | 31 +++
 rtl/ram_b_mem.sv | 110 +++++++++++
 tb/tb_ram_b_mem.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ram_b_pkg.sv
// Shared definitions for the ram_b data memory.
// Size codes follow the RISC-V funct3 encoding for loads and stores.
// Codes not listed here (011, 110, 111) behave as full-word accesses.
package ram_b_pkg;
    localparam int WORD_W = 32;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
endpackage

// File: rtl/ram_b_load_align.sv
// Load-side lane select and extension for ram_b_mem.
// Purely combinational.
// Ports:
//   word_i  raw 32-bit memory word
//   off_i   byte offset within the word (addra[1:0])
//   size_i  size code (B/H/W/BU/HU; other codes read as W)
//   data_o  selected lane, sign- or zero-extended to 32 bits
module ram_b_load_align
    import ram_b_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        size_i,
    output logic [WORD_W-1:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*off_i +: 8];
        // Halfword lane comes from off_i[1] only; a misaligned bit 0 is dropped.
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   data_o = {24'd0, byte_sel};
            SZ_H:    data_o = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/ram_b_mem.sv
// Byte-addressable data memory for the Tomasulo memory FU.
// Loads are combinational with sign/zero extension; stores are written on
// the rising edge with byte-lane enables. Upper address bits are ignored, so
// accesses wrap modulo the memory size.
// Optional build macro: RAM_B_MISALIGN_CHECK_EN adds a misalign output;
// misaligned writes are then suppressed and misaligned reads return 0.
// Ports:
//   clka         clock
//   rst_n        synchronous active-low reset; clears every word, blocks writes
//   addra        byte address
//   dina         store data (operand in the low bits)
//   wea          write enable
//   mem_u_b_h_w  size code
//   douta        combinational load data
//   misalign     (macro only) access is not naturally aligned
module ram_b_mem
    import ram_b_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_LSB_W  = 2
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic [31:0]       addra,
    input  logic [WORD_W-1:0] dina,
    input  logic              wea,
    input  logic [2:0]        mem_u_b_h_w,
`ifdef RAM_B_MISALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic [WORD_W-1:0] douta
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]  idx;
    logic [1:0]        off;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] ld_data;
    logic [3:0]        be;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] word_d;
    logic              we_d;
    logic              misalign_w;
    logic              blk;

    assign idx     = addra[ADDR_LSB_W+IDX_W-1:ADDR_LSB_W];
    assign off     = addra[ADDR_LSB_W-1:0];
    assign rd_word = mem_q[idx];

    // Address bits above the memory size are intentionally dropped (wrap).
    logic unused_addr;
    assign unused_addr = ^addra[31:ADDR_LSB_W+IDX_W];

`ifdef RAM_B_MISALIGN_CHECK_EN
    assign misalign = misalign_w;
    assign blk      = misalign_w;
`else
    assign blk = 1'b0;
    logic unused_mis;
    assign unused_mis = misalign_w;
`endif

    // Byte enables plus lane-replicated store data, so each enabled byte
    // simply takes the same-position byte of wdata.
    always_comb begin
        be         = 4'b1111;
        wdata      = dina;
        misalign_w = 1'b0;
        case (mem_u_b_h_w)
            SZ_B, SZ_BU: begin
                be    = 4'b0001 << off;
                wdata = {4{dina[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{dina[15:0]}};
                misalign_w = off[0];
            end
            default: begin
                be         = 4'b1111;
                misalign_w = (off != 2'b00);
            end
        endcase

        for (int i = 0; i < 4; i++)
            word_d[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rd_word[8*i +: 8];

        we_d = wea & ~blk;
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem_q[i] <= '0;
        end else if (we_d) begin
            mem_q[idx] <= word_d;
        end
    end

    ram_b_load_align u_load_align (
        .word_i (rd_word),
        .off_i  (off),
        .size_i (mem_u_b_h_w),
        .data_o (ld_data)
    );

    assign douta = blk ? '0 : ld_data;
endmodule

// File: tb/tb_ram_b_mem.sv
module tb_ram_b_mem;
    localparam int DEPTH  = 1024;
    localparam int NBYTES = DEPTH * 4;

    logic        clka = 1'b0;
    logic        rst_n;
    logic [31:0] addra;
    logic [31:0] dina;
    logic        wea;
    logic [2:0]  mem_u_b_h_w;
    logic [31:0] douta;
`ifdef RAM_B_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    always #5 clka = ~clka;

    ram_b_mem #(.DEPTH_WORDS(DEPTH), .ADDR_LSB_W(2)) dut (
        .clka        (clka),
        .rst_n       (rst_n),
        .addra       (addra),
        .dina        (dina),
        .wea         (wea),
        .mem_u_b_h_w (mem_u_b_h_w),
`ifdef RAM_B_MISALIGN_CHECK_EN
        .misalign    (misalign),
`endif
        .douta       (douta)
    );

    // Reference model: flat little-endian byte array.
    logic [7:0] ref_mem [NBYTES];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic int acc_bytes(input logic [2:0] sz);
        if (sz == 3'b000 || sz == 3'b100) return 1;
        if (sz == 3'b001 || sz == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit ref_mis(input logic [31:0] a, input logic [2:0] sz);
`ifdef RAM_B_MISALIGN_CHECK_EN
        return (a % acc_bytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] sz);
        int n    = acc_bytes(sz);
        int base = int'(a % NBYTES) / n * n;
        logic [31:0] v = 0;
        if (ref_mis(a, sz)) return 0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base+i];
        if (sz == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (sz == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    endtask

    // One write cycle; the model follows what the edge should do.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                      input logic en);
        int n, base;
        @(negedge clka);
        addra = a; dina = d; mem_u_b_h_w = sz; wea = en;
        @(posedge clka);
        if (!rst_n) ref_clear();
        else if (en && !ref_mis(a, sz)) begin
            n    = acc_bytes(sz);
            base = int'(a % NBYTES) / n * n;
            for (int i = 0; i < n; i++) ref_mem[base+i] = d[8*i +: 8];
        end
        @(negedge clka);
        wea = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] sz);
        @(negedge clka);
        addra = a; mem_u_b_h_w = sz; wea = 1'b0;
        #1;
        chk(tag, douta, ref_read(a, sz));
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  sz;
        rst_n = 1'b0; wea = 1'b0; addra = 0; dina = 0; mem_u_b_h_w = 3'b010;
        ref_clear();
        repeat (2) @(posedge clka);
        @(negedge clka);
        rst_n = 1'b1;

        // Reset state
        rd("rst_w0", 32'h0, 3'b010);
        rd("rst_wffc", 32'hFFC, 3'b010);
        chk("rst_lit", douta, 32'h0);

        // Word write then all read flavours
        wr(32'h10, 32'hDEADBEEF, 3'b010, 1'b1);
        rd("w10", 32'h10, 3'b010);
        chk("w10_lit", douta, 32'hDEADBEEF);
        rd("b13", 32'h13, 3'b000);
        chk("b13_lit", douta, 32'hFFFFFFDE);
        rd("bu13", 32'h13, 3'b100);
        chk("bu13_lit", douta, 32'h000000DE);
        rd("h12", 32'h12, 3'b001);
        chk("h12_lit", douta, 32'hFFFFDEAD);
        rd("hu10", 32'h10, 3'b101);
        chk("hu10_lit", douta, 32'h0000BEEF);

        // Partial writes keep the other lanes
        wr(32'h11, 32'hFFFFFF7F, 3'b000, 1'b1);
        rd("b_merge", 32'h10, 3'b010);
        chk("b_merge_lit", douta, 32'hDEAD7FEF);
        wr(32'h12, 32'hABCD1234, 3'b001, 1'b1);
        rd("h_merge", 32'h10, 3'b010);
        chk("h_merge_lit", douta, 32'h12347FEF);

        // Disabled write, then write under reset
        wr(32'h10, 32'hFFFFFFFF, 3'b010, 1'b0);
        rd("wea0", 32'h10, 3'b010);
        chk("wea0_lit", douta, 32'h12347FEF);
        rst_n = 1'b0;
        wr(32'h10, 32'h55555555, 3'b010, 1'b1);
        rst_n = 1'b1;
        rd("rst_wr", 32'h10, 3'b010);
        chk("rst_wr_lit", douta, 32'h0);

        // Wrap modulo memory size
        wr(DEPTH * 4 + 32'h8, 32'hA5A5A5A5, 3'b010, 1'b1);
        rd("wrap", 32'h8, 3'b010);
        chk("wrap_lit", douta, 32'hA5A5A5A5);

`ifdef RAM_B_MISALIGN_CHECK_EN
        wr(32'h20, 32'h01020304, 3'b010, 1'b1);
        @(negedge clka);
        addra = 32'h21; mem_u_b_h_w = 3'b010; #1;
        chk("mis_w21", {31'd0, misalign}, 32'd1);
        chk("mis_w21_d", douta, 32'h0);
        wr(32'h21, 32'hFFFFFFFF, 3'b010, 1'b1);
        rd("mis_keep", 32'h20, 3'b010);
        chk("mis_keep_lit", douta, 32'h01020304);
        @(negedge clka);
        addra = 32'h22; mem_u_b_h_w = 3'b001; #1;
        chk("mis_h22", {31'd0, misalign}, 32'd0);
`endif

        // Randomized mix against the model, small window plus high-bit aliasing
        for (int k = 0; k < 300; k++) begin
            a  = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) a = a | ($urandom() << 12);
            d  = $urandom();
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) wr(a, d, sz, 1'($urandom_range(0, 3) != 0));
            else rd("rand_rd", a, sz);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
